// File: rtl/mult_seq_pkg.sv
// Shared types and helpers for the multiplier sequencing stage.
// Holds operand/result widths, FSM state encoding and the FIFO entry layout.
package mult_seq_pkg;

  localparam int OP_W  = 16;
  localparam int RES_W = 32;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  typedef struct packed {
    logic [RES_W-1:0] data;
    logic             ovf;
  } res_entry_t;

  // Result for one op: with do_acc the product is added onto the (optionally
  // cleared) running sum and the carry out becomes the overflow flag.
  function automatic res_entry_t capture_result(
    input logic [RES_W-1:0] acc,
    input logic [RES_W-1:0] prod,
    input logic             do_acc,
    input logic             do_clr
  );
    logic [RES_W:0] sum;
    res_entry_t     r;
    sum = {1'b0, (do_clr ? {RES_W{1'b0}} : acc)} + {1'b0, prod};
    if (do_acc) begin
      r.data = sum[RES_W-1:0];
      r.ovf  = sum[RES_W];
    end else begin
      r.data = prod;
      r.ovf  = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Two-entry result FIFO; entry 0 is always the head so the outputs come
// straight from a register, and the head keeps its last value once drained.
module result_fifo
  import mult_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  res_entry_t push_data,
  input  logic       pop,
  output res_entry_t head,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);

  res_entry_t mem0_q, mem0_d;
  res_entry_t mem1_q, mem1_d;
  logic [1:0] count_q, count_d;
  logic       pop_ok_s;
  logic       push_ok_s;

  assign pop_ok_s  = pop && (count_q != 2'd0);
  assign push_ok_s = push && ((count_q != 2'd2) || pop_ok_s);

  // Next-state for storage and occupancy, shifting toward the head on pop.
  always_comb begin
    mem0_d  = mem0_q;
    mem1_d  = mem1_q;
    count_d = count_q;
    case ({push_ok_s, pop_ok_s})
      2'b10: begin
        if (count_q == 2'd0) begin
          mem0_d = push_data;
        end else begin
          mem1_d = push_data;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        if (count_q == 2'd2) begin
          mem0_d = mem1_q;
        end else begin
          mem0_d = mem0_q;
        end
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd2) begin
          mem0_d = mem1_q;
          mem1_d = push_data;
        end else begin
          mem0_d = push_data;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem0_q  <= '0;
      mem1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      mem0_q  <= mem0_d;
      mem1_q  <= mem1_d;
      count_q <= count_d;
    end
  end

  assign head  = mem0_q;
  assign count = count_q;
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencer around the external combinational 16x16 multiplier: holds operands
// for a settle time, captures/accumulates the product and queues results.
module mult_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  input  logic              in_acc,
  input  logic              in_clr,
  output logic [OP_W-1:0]   mult_a,
  output logic [OP_W-1:0]   mult_b,
  input  logic [RES_W-1:0]  mult_c,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out_data,
  output logic              out_ovf,
  output logic              busy
);

  localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0]  mult_a_q, mult_a_d;
  logic [OP_W-1:0]  mult_b_q, mult_b_d;
  logic [RES_W-1:0] acc_q, acc_d;
  logic             op_acc_q, op_acc_d;
  logic             op_clr_q, op_clr_d;

  logic             in_ready_s;
  logic             push_s;
  logic             pop_s;
  res_entry_t       push_entry_s;
  res_entry_t       fifo_head_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [1:0]       fifo_count_s;

  assign pop_s        = !fifo_empty_s && out_ready;
  assign push_entry_s = capture_result(acc_q, mult_c, op_acc_q, op_clr_q);

  // FSM next state, operand latching and accumulator update.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mult_a_d   = mult_a_q;
    mult_b_d   = mult_b_q;
    acc_d      = acc_q;
    op_acc_d   = op_acc_q;
    op_clr_d   = op_clr_q;
    in_ready_s = 1'b0;
    push_s     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_s = (fifo_count_s < 2'(FIFO_DEPTH));
        if (in_valid && in_ready_s) begin
          mult_a_d = in_a;
          mult_b_d = in_b;
          op_acc_d = in_acc;
          op_clr_d = in_clr;
          cnt_d    = SETTLE_INIT;
          state_d  = SETTLE;
        end else begin
          state_d  = IDLE;
        end
      end
      SETTLE: begin
        if (cnt_q != {CNT_W{1'b0}}) begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        // Room was reserved at acceptance; the guard only covers the head leaving.
        push_s = !fifo_full_s || pop_s;
        if (op_acc_q) begin
          acc_d = push_entry_s.data;
        end else if (op_clr_q) begin
          acc_d = {RES_W{1'b0}};
        end else begin
          acc_d = acc_q;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      mult_a_q <= {OP_W{1'b0}};
      mult_b_q <= {OP_W{1'b0}};
      acc_q    <= {RES_W{1'b0}};
      op_acc_q <= 1'b0;
      op_clr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mult_a_q <= mult_a_d;
      mult_b_q <= mult_b_d;
      acc_q    <= acc_d;
      op_acc_q <= op_acc_d;
      op_clr_q <= op_clr_d;
    end
  end

  result_fifo u_result_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .head      (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  assign in_ready  = in_ready_s;
  assign mult_a    = mult_a_q;
  assign mult_b    = mult_b_q;
  assign out_valid = !fifo_empty_s;
  assign out_data  = fifo_head_s.data;
  assign out_ovf   = fifo_head_s.ovf;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: directed vector table, reset and
// backpressure sequences, and randomized ops against a behavioural model.
module tb_mult_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = 16'd0;
  logic [15:0] in_b = 16'd0;
  logic        in_acc = 1'b0;
  logic        in_clr = 1'b0;
  logic [15:0] mult_a;
  logic [15:0] mult_b;
  logic [31:0] mult_c;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_ovf;
  logic        busy;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] acc_m = 32'd0;
  logic [32:0] expq[$];

  // The external array multiplier, modelled behaviourally.
  assign mult_c = 32'(mult_a) * 32'(mult_b);

  always #5 clk = ~clk;

  mult_seq_ctrl #(.SETTLE_CYCLES(4), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_acc(in_acc), .in_clr(in_clr),
    .mult_a(mult_a), .mult_b(mult_b), .mult_c(mult_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .busy(busy)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        acc;
    logic        clr;
    logic [31:0] exp_d;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Spec-level model: result is a*b, optionally summed onto the running total.
  task automatic model_op(input logic [15:0] a, input logic [15:0] b,
                          input logic acc, input logic clr, output logic [32:0] res);
    logic [31:0] prod;
    logic [31:0] base;
    logic [32:0] s;
    prod = 32'(a) * 32'(b);
    base = clr ? 32'd0 : acc_m;
    s    = {1'b0, base} + {1'b0, prod};
    if (acc) begin
      res   = s;
      acc_m = s[31:0];
    end else begin
      res   = {1'b0, prod};
      acc_m = base;
    end
  endtask

  // One op with out_ready=1 and an empty FIFO; reports result and timing.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic acc,
                        input logic clr, output logic [31:0] d, output logic ovf,
                        output int lat, output int ready_low, output int hold_err,
                        output int busy_cnt);
    int          w;
    logic [32:0] r;
    in_a = a; in_b = b; in_acc = acc; in_clr = clr; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin step(); w++; end
    if (w >= 50) timeout_fail("op_accept");
    step();
    model_op(a, b, acc, clr, r);
    in_valid = 1'b0;
    in_a = 16'($urandom); in_b = 16'($urandom); in_acc = ~acc; in_clr = ~clr;
    lat = 0; ready_low = 0; hold_err = 0; busy_cnt = 0;
    while (!out_valid && lat < 40) begin
      if (mult_a !== a || mult_b !== b) hold_err++;
      if (!in_ready) ready_low++;
      if (busy) busy_cnt++;
      step();
      lat++;
    end
    if (lat >= 40) timeout_fail("op_result");
    d = out_data;
    ovf = out_ovf;
    step();
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    int w;
    in_a = a; in_b = b; in_acc = 1'b0; in_clr = 1'b0; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin step(); w++; end
    if (w >= 50) timeout_fail("issue_accept");
    step();
    in_valid = 1'b0;
  endtask

  // Random back-to-back ops; results matched in order against the model queue.
  task automatic rand_phase(input int nops, input bit rand_ready);
    int          sent, got, cyc, max_q;
    bit          acc_fire, pop_fire;
    logic [32:0] e;
    logic [32:0] r;
    expq.delete();
    sent = 0; got = 0; cyc = 0; max_q = 0;
    out_ready = rand_ready ? 1'($urandom) : 1'b1;
    in_a = 16'($urandom); in_b = 16'($urandom);
    in_acc = 1'($urandom); in_clr = 1'($urandom); in_valid = 1'b1;
    while (got < nops && cyc < 3000) begin
      acc_fire = in_valid && in_ready;
      pop_fire = out_valid && out_ready;
      if (pop_fire) begin
        if (expq.size() == 0) begin
          timeout_fail("rand_unexpected_result");
        end else begin
          e = expq.pop_front();
          check("rand_result", {31'd0, out_ovf, out_data}, {31'd0, e});
        end
        got++;
      end
      if (acc_fire) begin
        model_op(in_a, in_b, in_acc, in_clr, r);
        expq.push_back(r);
        sent++;
      end
      if (expq.size() > max_q) max_q = expq.size();
      step();
      cyc++;
      if (acc_fire) begin
        if (sent < nops) begin
          in_a = 16'($urandom); in_b = 16'($urandom);
          in_acc = 1'($urandom); in_clr = 1'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
      if (rand_ready) out_ready = 1'($urandom);
    end
    if (cyc >= 3000) timeout_fail("rand_phase");
    check("rand_count", 64'(got), 64'(nops));
    check("rand_leftover", 64'(expq.size()), 64'd0);
    if (!rand_ready) check("rand_max_outstanding_le1", 64'(max_q <= 1), 64'd1);
    out_ready = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        ovf;
    int          lat, rl, he, bc, cnt_r, w;

    vecs[0] = '{16'd3,      16'd5,      1'b0, 1'b0, 32'd15,         1'b0};
    vecs[1] = '{16'd100,    16'd200,    1'b1, 1'b1, 32'd20000,      1'b0};
    vecs[2] = '{16'd300,    16'd400,    1'b1, 1'b0, 32'h000222E0,   1'b0};
    vecs[3] = '{16'd2,      16'd2,      1'b0, 1'b0, 32'd4,          1'b0};
    vecs[4] = '{16'd1,      16'd1,      1'b1, 1'b0, 32'h000222E1,   1'b0};
    vecs[5] = '{16'hFFFF,   16'hFFFF,   1'b1, 1'b1, 32'hFFFE0001,   1'b0};
    vecs[6] = '{16'hFFFF,   16'hFFFF,   1'b1, 1'b0, 32'hFFFC0002,   1'b1};

    // Reset state
    step(); step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_mult_a", 64'(mult_a), 64'd0);
    rst_n = 1'b1;
    step();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_ovf", 64'(out_ovf), 64'd0);

    // Directed vector table
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].acc, vecs[i].clr, d, ovf, lat, rl, he, bc);
      check($sformatf("vec%0d_data", i), 64'(d), 64'(vecs[i].exp_d));
      check($sformatf("vec%0d_ovf", i), 64'(ovf), 64'(vecs[i].exp_ovf));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd5);
      check($sformatf("vec%0d_ready_low", i), 64'(rl), 64'd5);
      check($sformatf("vec%0d_busy", i), 64'(bc), 64'd5);
      check($sformatf("vec%0d_hold", i), 64'(he), 64'd0);
    end
    check("empty_hold_data", 64'(out_data), 64'hFFFC0002);
    check("empty_out_valid", 64'(out_valid), 64'd0);

    // Reset in the middle of SETTLE discards the op and clears the accumulator
    in_a = 16'd9; in_b = 16'd9; in_acc = 1'b1; in_clr = 1'b0; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin step(); w++; end
    step();
    in_valid = 1'b0;
    step(); step();
    check("midop_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midop_rst_busy", 64'(busy), 64'd0);
    check("midop_rst_mult_a", 64'(mult_a), 64'd0);
    check("midop_rst_mult_b", 64'(mult_b), 64'd0);
    check("midop_rst_out_valid", 64'(out_valid), 64'd0);
    step();
    rst_n = 1'b1;
    acc_m = 32'd0;
    step();
    check("midop_in_ready", 64'(in_ready), 64'd1);
    cnt_r = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) cnt_r++;
      step();
    end
    check("midop_no_result", 64'(cnt_r), 64'd0);
    run_op(16'd1, 16'd1, 1'b1, 1'b0, d, ovf, lat, rl, he, bc);
    check("midop_acc_cleared", 64'(d), 64'd1);

    // Backpressure: FIFO fills, third op waits for the first pop
    out_ready = 1'b0;
    issue(16'd7, 16'd1);
    issue(16'd7, 16'd2);
    in_a = 16'd7; in_b = 16'd3; in_acc = 1'b0; in_clr = 1'b0; in_valid = 1'b1;
    cnt_r = 0;
    for (int i = 0; i < 15; i++) begin
      if (in_ready) cnt_r++;
      step();
    end
    check("bp_in_ready_low", 64'(cnt_r), 64'd0);
    check("bp_full_valid", 64'(out_valid), 64'd1);
    check("bp_head_7", 64'(out_data), 64'd7);
    out_ready = 1'b1;
    step();
    check("bp_head_14", 64'(out_data), 64'd14);
    check("bp_ready_after_pop", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check("bp_third_accepted", 64'(busy), 64'd1);
    check("bp_drained", 64'(out_valid), 64'd0);
    w = 0;
    while (!out_valid && w < 20) begin step(); w++; end
    if (w >= 20) timeout_fail("bp_third_result");
    check("bp_head_21", 64'(out_data), 64'd21);
    step();

    // Randomized: always-ready consumer, then a stalling consumer
    rand_phase(20, 1'b0);
    rand_phase(20, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
